dram_stream_reader: RTL and testbench
=====================================

# dram_stream_reader

Read-side initiator for the image DRAM: fetches a rectangular pixel region (base address, width, height, row stride) and emits it as a raster-ordered valid/ready pixel stream to the processing datapath. Drives the DRAM's address bus and samples its combinational read data. Writes and end-of-simulation control stay with the existing write path.

## Interface
- ADDR_W, 18, DRAM word-address width (262144 words)
- DATA_W, 9, pixel/word width
- DIM_W, 10, width/height field width (1..512 legal)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  address of first pixel; latched on accepted start
- width  in  DIM_W  pixels per row; latched on accepted start
- height  in  DIM_W  rows; latched on accepted start
- stride  in  ADDR_W  address step between row starts; latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at transfer completion
- mem_addr  out  ADDR_W  DRAM address (to DRAM addr)
- mem_din  in  DATA_W  DRAM read data (from DRAM dout, combinational)
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  output pixel
- m_eol  out  1  last pixel of row (only with DRAM_RD_EOL_EN)

## Operation
- FSM: IDLE -> RUN -> DRAIN -> IDLE; done pulses on the DRAIN->IDLE edge.
- IDLE: start=1 latches base/width/height/stride, row_base=base_addr, col=0, row=0, goes to RUN. start while busy is ignored.
- start with width==0 or height==0: no beats; done pulses the next cycle, busy stays 0.
- mem_addr = row_base + col, modulo 2^ADDR_W (wraps silently past 262143).
- RUN: output register captures mem_din when (!m_valid || m_ready); that capture advances col; at col==width-1: col=0, row_base+=stride (mod 2^ADDR_W), row++.
- Capture of pixel (height-1, width-1) moves to DRAIN; no further captures.
- DRAIN: wait until m_valid && m_ready, then done=1 for one cycle, busy=0, IDLE.
- m_data/m_valid held stable while m_valid && !m_ready (AXI-style; valid never drops without handshake).
- Output register only; no skid buffer needed since DRAM read is same-cycle.
- Reset values: busy=0, done=0, m_valid=0, m_data=0, m_eol=0, mem_addr=0 (row_base=col=0), state=IDLE.
- Reset asserted mid-transfer aborts immediately; no done pulse, pending beat discarded.

## Timing
- Cycle 0: start sampled. Cycle 1: RUN, busy=1, mem_addr=base_addr. Cycle 2: first m_valid.
- m_ready held high: one pixel/cycle; last beat at cycle W*H+1, done at cycle W*H+2.
- m_ready low for N cycles stalls address generation exactly N cycles; mem_addr stays constant while stalled.
- done and busy never high together; done cycle is IDLE, so start in the done cycle is accepted.

## Configuration
- DRAM_RD_EOL_EN defined: m_eol port present; registered alongside m_data, high on the last pixel of each row, held with the beat.
- Undefined: m_eol port and its logic absent; stream carries no row framing.

## Structure
- Package dram_rd_pkg: ADDR_W/DATA_W/DIM_W defaults, state enum (IDLE, RUN, DRAIN).
- Sub-module dram_rd_addr_gen: col/row counters, row_base accumulator, last-of-row/last-of-frame flags, advance enable input.
- Top holds FSM, output register, done/busy.

## Test plan
- base=0x00010, width=4, height=3, stride=8, m_ready=1, DRAM[i]=i&0x1FF -> beats 0x10..0x13, 0x18..0x1B, 0x20..0x23; done at cycle 14.
- Same region, m_ready toggling 1/0 each cycle -> identical 12-beat sequence, data stable during stalls, mem_addr frozen while stalled, done after 12th handshake.
- base=0x3FFFE, width=4, height=1 -> addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- width=0, height=5, start -> no m_valid, done pulse at cycle 1, busy never high; second start during a 512x1 transfer ignored.
- rst_n low at cycle 5 of a 4x3 transfer -> all outputs 0 asynchronously, no done; new start after release reruns from base.
- DRAM_RD_EOL_EN: width=3, height=2 -> m_eol high on beats 3 and 6 only.

Source files
------------

// File: rtl/dram_rd_pkg.sv
// Shared parameters and FSM state type for the DRAM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dram_rd_pkg;
   localparam int ADDR_W = 18;   // DRAM word-address width
   localparam int DATA_W = 9;    // pixel / DRAM word width
   localparam int DIM_W  = 10;   // width/height field width (1..512)

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/dram_stream_reader_if.sv
// DRAM read bus plus the outgoing valid/ready pixel stream.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the slave side stalls the master.
// Optional m_eol member present only when DRAM_RD_EOL_EN is defined.
interface dram_stream_reader_if;
   import dram_rd_pkg::*;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
`ifdef DRAM_RD_EOL_EN
   logic              m_eol;
`endif

   modport master (
      output mem_addr,
      input  mem_din,
      output m_valid,
      input  m_ready,
`ifdef DRAM_RD_EOL_EN
      output m_eol,
`endif
      output m_data
   );

   modport slave (
      input  mem_addr,
      output mem_din,
      input  m_valid,
      output m_ready,
`ifdef DRAM_RD_EOL_EN
      input  m_eol,
`endif
      input  m_data
   );
endinterface

// File: rtl/dram_rd_addr_gen.sv
// Raster address generator: col/row counters and row_base accumulator.
// Latency: address is combinational from state; advances on the cycle after i_advance.
// Backpressure: holds the current address whenever i_advance is low.
module dram_rd_addr_gen
   import dram_rd_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W-1:0] i_stride,
   input  logic [DIM_W-1:0]  i_width,
   input  logic [DIM_W-1:0]  i_height,
   input  logic              i_advance,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last_col,
   output logic              o_last_frame
);
   logic [ADDR_W-1:0] r_row_base;
   logic [ADDR_W-1:0] r_stride;
   logic [DIM_W-1:0]  r_col;
   logic [DIM_W-1:0]  r_row;
   logic [DIM_W-1:0]  r_width_m1;
   logic [DIM_W-1:0]  r_height_m1;

   // Address wraps modulo 2^ADDR_W by plain truncation of the sum.
   assign o_addr       = r_row_base + ADDR_W'(r_col);
   assign o_last_col   = (r_col == r_width_m1);
   assign o_last_frame = o_last_col && (r_row == r_height_m1);

   // Load the region on start, then step one pixel per advance in raster order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_base  <= '0;
         r_stride    <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_width_m1  <= '0;
         r_height_m1 <= '0;
      end else if (i_load) begin
         r_row_base  <= i_base;
         r_stride    <= i_stride;
         r_col       <= '0;
         r_row       <= '0;
         r_width_m1  <= i_width - DIM_W'(1);
         r_height_m1 <= i_height - DIM_W'(1);
      end else if (i_advance) begin
         if (o_last_col) begin
            r_col      <= '0;
            r_row_base <= r_row_base + r_stride;
            r_row      <= r_row + DIM_W'(1);
         end else begin
            r_col      <= r_col + DIM_W'(1);
         end
      end
   end
endmodule

// File: rtl/dram_stream_reader.sv
// Fetches a rectangular DRAM region and streams it out in raster order.
// Latency: first beat valid two cycles after start; one pixel/cycle when unstalled.
// Backpressure: m_ready low freezes the output beat and the DRAM address.
// Optional feature macro: DRAM_RD_EOL_EN adds the m_eol row-end flag.
module dram_stream_reader
   import dram_rd_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [DIM_W-1:0]     width,
   input  logic [DIM_W-1:0]     height,
   input  logic [ADDR_W-1:0]    stride,
   output logic                 busy,
   output logic                 done,
   dram_stream_reader_if.master bus
);
   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_load;
   logic              w_capture;
   logic              w_done_set;
   logic              w_zero;
   logic              w_last_frame;
   logic [ADDR_W-1:0] w_addr;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_done;
`ifdef DRAM_RD_EOL_EN
   logic              w_last_col;
   logic              r_eol;
`endif

   assign w_zero = (width == '0) || (height == '0);

   dram_rd_addr_gen u_addr_gen (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_load       (w_load),
      .i_base       (base_addr),
      .i_stride     (stride),
      .i_width      (width),
      .i_height     (height),
      .i_advance    (w_capture),
      .o_addr       (w_addr),
`ifdef DRAM_RD_EOL_EN
      .o_last_col   (w_last_col),
`else
      .o_last_col   (),
`endif
      .o_last_frame (w_last_frame)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state and per-cycle controls; an empty region completes without leaving IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_done_set  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               if (w_zero) w_done_set  = 1'b1;
               else        w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_capture = !r_valid || bus.m_ready;
            if (w_capture && w_last_frame) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (r_valid && bus.m_ready) begin
               w_done_set  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output register: capture DRAM data when the slot is free, else hold the beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
`ifdef DRAM_RD_EOL_EN
         r_eol   <= 1'b0;
`endif
      end else if (w_capture) begin
         r_valid <= 1'b1;
         r_data  <= bus.mem_din;
`ifdef DRAM_RD_EOL_EN
         r_eol   <= w_last_col;
`endif
      end else if (r_valid && bus.m_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Single-cycle completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_done <= 1'b0;
      else        r_done <= w_done_set;
   end

   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign bus.mem_addr = w_addr;
   assign bus.m_valid  = r_valid;
   assign bus.m_data   = r_data;
`ifdef DRAM_RD_EOL_EN
   assign bus.m_eol    = r_eol;
`endif
endmodule

// File: tb/tb_dram_stream_reader.sv
// Self-checking bench for dram_stream_reader: table of regions plus random regions,
// each checked beat-by-beat against a raster-order expected queue.
module tb_dram_stream_reader;
   import dram_rd_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [DIM_W-1:0]  width = '0;
   logic [DIM_W-1:0]  height = '0;
   logic [ADDR_W-1:0] stride = '0;
   logic              busy;
   logic              done;
   logic              scramble = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dram_stream_reader_if bus();

   // DRAM content: either word index (i & 0x1FF) or an address hash.
   function automatic logic [DATA_W-1:0] dram_word(input logic [ADDR_W-1:0] a, input logic scr);
      logic [ADDR_W-1:0] h;
      h = a ^ (a >> 9);
      if (scr) return h[DATA_W-1:0] ^ 9'h0A5;
      return a[DATA_W-1:0];
   endfunction

   assign bus.mem_din = dram_word(bus.mem_addr, scramble);

   dram_stream_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .width     (width),
      .height    (height),
      .stride    (stride),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              eol;
   } beat_t;

   beat_t exp_q[$];

   typedef struct {
      logic [ADDR_W-1:0] base;
      int                w;
      int                h;
      logic [ADDR_W-1:0] stride;
      int                rmode;   // 0: ready high, 1: toggle, 2: random
      int                ign_cyc; // cycle to pulse an ignored start (0 = none)
      logic              scr;
   } vec_t;

   // Runs one transfer; entered and left at a negedge (left in the done cycle).
   task automatic run_xfer(input string tag, input vec_t v);
      int                nbeats;
      int                budget;
      int                got;
      int                last_hs;
      int                exp_cyc;
      bit                fin;
      bit                pstall;
      logic [DATA_W-1:0] pdata;
      logic [ADDR_W-1:0] paddr;
      beat_t             e;
      nbeats  = v.w * v.h;
      got     = 0;
      last_hs = -1;
      fin     = 0;
      pstall  = 0;
      pdata   = '0;
      paddr   = '0;
      scramble = v.scr;
      exp_q.delete();
      for (int r = 0; r < v.h; r++) begin
         for (int c = 0; c < v.w; c++) begin
            longint a;
            a     = (longint'(v.base) + longint'(r) * longint'(v.stride) + longint'(c)) % 262144;
            e.d   = dram_word(ADDR_W'(a), v.scr);
            e.eol = (c == v.w - 1);
            exp_q.push_back(e);
         end
      end
      base_addr = v.base;
      width     = DIM_W'(v.w);
      height    = DIM_W'(v.h);
      stride    = v.stride;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      base_addr = ADDR_W'($urandom);
      width     = DIM_W'($urandom);
      height    = DIM_W'($urandom);
      stride    = ADDR_W'($urandom);
      budget    = nbeats * 4 + 30;
      for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
         @(negedge clk);
         case (v.rmode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = cyc[0];
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
         if (cyc == v.ign_cyc) begin
            start     = 1'b1;
            base_addr = v.base + ADDR_W'(256);
            width     = DIM_W'(3);
            height    = DIM_W'(3);
         end else begin
            start = 1'b0;
         end
         if (pstall) begin
            chk({tag, " hold valid"}, 32'(bus.m_valid), 32'd1);
            chk({tag, " hold data"}, 32'(bus.m_data), 32'(pdata));
            chk({tag, " addr frozen"}, 32'(bus.mem_addr), 32'(paddr));
         end
         chk({tag, " busy&done"}, 32'(busy & done), 32'd0);
         if (cyc == 1 && nbeats > 0) begin
            chk({tag, " c1 busy"}, 32'(busy), 32'd1);
            chk({tag, " c1 addr"}, 32'(bus.mem_addr), 32'(v.base));
            chk({tag, " c1 valid"}, 32'(bus.m_valid), 32'd0);
            chk({tag, " c1 done"}, 32'(done), 32'd0);
         end
         if (nbeats == 0) chk({tag, " no valid"}, 32'(bus.m_valid), 32'd0);
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               chk({tag, " extra beat"}, 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk({tag, " data"}, 32'(bus.m_data), 32'(e.d));
`ifdef DRAM_RD_EOL_EN
               chk({tag, " eol"}, 32'(bus.m_eol), 32'(e.eol));
`endif
               got++;
               last_hs = cyc;
            end
         end
         pstall = bus.m_valid && !bus.m_ready;
         pdata  = bus.m_data;
         paddr  = bus.mem_addr;
         if (done) begin
            fin = 1;
            if (nbeats == 0)       exp_cyc = 1;
            else if (v.rmode == 0) exp_cyc = nbeats + 2;
            else                   exp_cyc = last_hs + 1;
            chk({tag, " beats"}, 32'(got), 32'(nbeats));
            chk({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
            chk({tag, " busy at done"}, 32'(busy), 32'd0);
            chk({tag, " valid at done"}, 32'(bus.m_valid), 32'd0);
         end else begin
            chk({tag, " busy"}, 32'(busy), 32'(nbeats > 0));
         end
      end
      start = 1'b0;
      if (!fin) chk({tag, " done timeout"}, 32'd0, 32'd1);
   endtask

   vec_t vecs [8];

   initial begin
      vec_t rv;
      vecs[0] = '{base: 18'h00010, w: 4,   h: 3, stride: 18'd8,     rmode: 0, ign_cyc: 0, scr: 1'b0};
      vecs[1] = '{base: 18'h00010, w: 4,   h: 3, stride: 18'd8,     rmode: 1, ign_cyc: 0, scr: 1'b0};
      vecs[2] = '{base: 18'h3FFFE, w: 4,   h: 1, stride: 18'd0,     rmode: 0, ign_cyc: 0, scr: 1'b0};
      vecs[3] = '{base: 18'h00055, w: 0,   h: 5, stride: 18'd1,     rmode: 0, ign_cyc: 0, scr: 1'b0};
      vecs[4] = '{base: 18'h00100, w: 512, h: 1, stride: 18'h200,   rmode: 0, ign_cyc: 5, scr: 1'b1};
      vecs[5] = '{base: 18'h00020, w: 3,   h: 2, stride: 18'h10,    rmode: 0, ign_cyc: 0, scr: 1'b0};
      vecs[6] = '{base: 18'h3FFF0, w: 5,   h: 3, stride: 18'h3FFF8, rmode: 2, ign_cyc: 0, scr: 1'b1};
      vecs[7] = '{base: 18'h00000, w: 7,   h: 0, stride: 18'd4,     rmode: 0, ign_cyc: 0, scr: 1'b0};

      bus.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset valid", 32'(bus.m_valid), 32'd0);
      chk("reset data", 32'(bus.m_data), 32'd0);
      chk("reset addr", 32'(bus.mem_addr), 32'd0);
`ifdef DRAM_RD_EOL_EN
      chk("reset eol", 32'(bus.m_eol), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_xfer($sformatf("vec%0d", i), vecs[i]);
      end

      // Reset in the middle of a 4x3 transfer aborts it with no done.
      scramble    = 1'b0;
      bus.m_ready = 1'b1;
      base_addr   = 18'h00010;
      width       = DIM_W'(4);
      height      = DIM_W'(3);
      stride      = 18'd8;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("pre-reset valid", 32'(bus.m_valid), 32'd1);
      chk("pre-reset busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort valid", 32'(bus.m_valid), 32'd0);
      chk("abort data", 32'(bus.m_data), 32'd0);
      chk("abort addr", 32'(bus.mem_addr), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort no done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset done", 32'(done), 32'd0);
      run_xfer("rerun", vecs[0]);

      // Random regions, random backpressure, hashed DRAM content.
      for (int k = 0; k < 6; k++) begin
         rv.base    = ADDR_W'($urandom);
         rv.w       = int'($urandom_range(1, 6));
         rv.h       = int'($urandom_range(1, 5));
         rv.stride  = ADDR_W'($urandom);
         rv.rmode   = 2;
         rv.ign_cyc = int'($urandom_range(0, 8));
         rv.scr     = 1'b1;
         run_xfer($sformatf("rnd%0d", k), rv);
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
